// File: rtl/sram_pkg.sv
// Shared state encoding and lane-map constants for the two-requester SRAM arbiter.
// The strobe helper turns a latched request into the ACCESS-phase strobe pattern.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Byte-enable bit positions feeding each chip's lower/upper byte strobe
    localparam int BE_LB0 = 0;
    localparam int BE_UB0 = 1;
    localparam int BE_LB1 = 2;
    localparam int BE_UB1 = 3;

    typedef struct packed {
        logic [1:0] ce_n;
        logic [1:0] ub_n;
        logic [1:0] lb_n;
        logic [1:0] we_n;
        logic [1:0] oe_n;
    } strobe_t;

    function automatic strobe_t access_strobes(input logic we, input logic [3:0] be);
        strobe_t s;
        s = '1;
        if (we) begin
            s.lb_n[0] = ~be[BE_LB0];
            s.ub_n[0] = ~be[BE_UB0];
            s.lb_n[1] = ~be[BE_LB1];
            s.ub_n[1] = ~be[BE_UB1];
            s.ce_n[0] = ~(be[BE_LB0] | be[BE_UB0]);
            s.ce_n[1] = ~(be[BE_LB1] | be[BE_UB1]);
            s.we_n    = s.ce_n;
        end else begin
            // Reads always fetch the full word; be does not matter
            s.ce_n = 2'b00;
            s.ub_n = 2'b00;
            s.lb_n = 2'b00;
            s.oe_n = 2'b00;
        end
        return s;
    endfunction

endpackage

// File: rtl/sram_rr_grant.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module sram_rr_grant (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_grant = i_req[1];
        if (&i_req) begin
            o_grant = ~i_last;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter for a pair of 16-bit async SRAMs forming one 32-bit word.
// Handshake: mN_req is held with stable fields until mN_ack, which pulses for one cycle.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [17:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [17:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [17:0] ram_addr,
    input  logic [31:0] ram_data_read,
    output logic [31:0] ram_data_write,
    output logic        ram_data_is_output,
    output logic [1:0]  ram_ce_n,
    output logic [1:0]  ram_ub_n,
    output logic [1:0]  ram_lb_n,
    output logic [1:0]  ram_we_n,
    output logic [1:0]  ram_oe_n,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic        r_sel;
    logic        r_we;
    logic [3:0]  r_be;
    logic [17:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        r_m0_ack;
    logic        r_m1_ack;
    strobe_t     r_strb;
    strobe_t     w_strb_nxt;
    logic        r_drive;
    logic        w_drive_nxt;
    logic        w_we_nxt;
    logic [3:0]  w_be_nxt;
    logic        w_grant;
    logic        w_gvalid;
    logic        w_take;
    logic        w_last_access;

    sram_rr_grant u_grant (
        .i_req   ({m1_req, m0_req}),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_valid (w_gvalid)
    );

    assign w_take        = (r_state == ST_IDLE) && w_gvalid;
    assign w_last_access = (r_state == ST_ACCESS) && (r_cnt == LAST_CNT);

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_be_nxt    = r_be;
        case (r_state)
            ST_IDLE: begin
                if (w_gvalid) begin
                    w_state_nxt = ST_ACCESS;
                    w_we_nxt    = w_grant ? m1_we : m0_we;
                    w_be_nxt    = w_grant ? m1_be : m0_be;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered pins line up with r_state
        w_strb_nxt  = '1;
        w_drive_nxt = 1'b0;
        if (w_state_nxt == ST_ACCESS) begin
            w_strb_nxt = access_strobes(w_we_nxt, w_be_nxt);
        end
        if (w_state_nxt != ST_IDLE) begin
            w_drive_nxt = w_we_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_strb     <= '1;
            r_drive    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_we     <= w_we_nxt;
            r_be     <= w_be_nxt;
            r_strb   <= w_strb_nxt;
            r_drive  <= w_drive_nxt;
            r_cnt    <= (r_state == ST_ACCESS) ? r_cnt + 4'd1 : 4'd0;
            r_m0_ack <= w_last_access && !r_sel;
            r_m1_ack <= w_last_access && r_sel;
            if (w_take) begin
                r_sel   <= w_grant;
                r_last  <= w_grant;
                r_addr  <= w_grant ? m1_addr : m0_addr;
                r_wdata <= w_grant ? m1_wdata : m0_wdata;
            end
            if (w_last_access && !r_we) begin
                if (r_sel) begin
                    r_m1_rdata <= ram_data_read;
                end else begin
                    r_m0_rdata <= ram_data_read;
                end
            end
        end
    end

    assign m0_ack             = r_m0_ack;
    assign m1_ack             = r_m1_ack;
    assign m0_rdata           = r_m0_rdata;
    assign m1_rdata           = r_m1_rdata;
    assign ram_addr           = r_addr;
    assign ram_data_write     = r_wdata;
    assign ram_data_is_output = r_drive;
    assign ram_ce_n           = r_strb.ce_n;
    assign ram_ub_n           = r_strb.ub_n;
    assign ram_lb_n           = r_strb.lb_n;
    assign ram_we_n           = r_strb.we_n;
    assign ram_oe_n           = r_strb.oe_n;
    assign dbg_state          = r_state;

endmodule
